// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice: instruction field
// positions, the default reset PC and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned FUNCT_HI  = 5;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned JIDX_HI   = 25;
  localparam int unsigned JIDX_LO   = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-PC selection: sequential PC+4 (wrapping), taken
// branch with sign-extended word offset, or pseudo-direct jump.
// Jump has priority over a taken branch.
import mips_pkg::*;

module pc_next #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [JIDX_HI:JIDX_LO] instr_low,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] branch_off;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] jump_target;

  assign pc_plus4      = pc + ADDR_WIDTH'(4);
  assign branch_off    = {{(ADDR_WIDTH-18){instr_low[IMM_HI]}}, instr_low[IMM_HI:IMM_LO], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[ADDR_WIDTH-1:28], instr_low[JIDX_HI:JIDX_LO], 2'b00};

  // Priority select of the redirect target.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: two-state FETCH/HOLD machine that requests a word
// at PC, holds it for decode until handshaked, then advances PC.
// Optional feature: define IFU_INSTR_COUNT_EN to add the InstrCount output.
import mips_pkg::*;

module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [5:0]            Opcode,
  output logic [5:0]            Funct,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  input  logic                  Jump,
  input  logic                  Branch,
  input  logic                  Zero
`ifdef IFU_INSTR_COUNT_EN
  ,
  output logic [31:0]           InstrCount
`endif
);

  ifu_state_t            state;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  handshake;

  assign imem_addr = PC;
  assign Opcode    = Instr[OPCODE_HI:OPCODE_LO];
  assign Funct     = Instr[FUNCT_HI:FUNCT_LO];
  assign handshake = (state == HOLD) && InstrReady;

  pc_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_next (
    .pc       (PC),
    .instr_low(Instr[JIDX_HI:JIDX_LO]),
    .jump     (Jump),
    .branch   (Branch),
    .zero     (Zero),
    .next_pc  (next_pc)
  );

  // Fetch FSM with registered request/valid; reset overrides ack and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      PC         <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      Instr      <= '0;
      InstrValid <= 1'b0;
      imem_req   <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            Instr      <= imem_rdata;
            state      <= HOLD;
            imem_req   <= 1'b0;
            InstrValid <= 1'b1;
          end
        end
        HOLD: begin
          if (InstrReady) begin
            PC         <= next_pc;
            state      <= FETCH;
            imem_req   <= 1'b1;
            InstrValid <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

`ifdef IFU_INSTR_COUNT_EN
  // Count of decode handshakes, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrCount <= '0;
    end else if (handshake) begin
      InstrCount <= InstrCount + 32'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized fetch traffic against a behavioural next-PC model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [31:0] PC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Jump;
  logic        Branch;
  logic        Zero;
`ifdef IFU_INSTR_COUNT_EN
  logic [31:0] InstrCount;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] exp_pc  = 32'h0;
  logic [31:0] exp_cnt = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .Instr     (Instr),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .PC        (PC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Jump      (Jump),
    .Branch    (Branch),
    .Zero      (Zero)
`ifdef IFU_INSTR_COUNT_EN
    ,
    .InstrCount(InstrCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule expressed with plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                              input bit j, input bit b, input bit z);
    logic [31:0] p4;
    logic [15:0] imm;
    int          off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      imm = ins[15:0];
      off = int'($signed(imm)) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  task automatic chk_fetching(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_valid"}, 32'(InstrValid), 32'd0);
    chk({tag, "_addr"}, imem_addr, exp_pc);
    chk({tag, "_align"}, imem_addr & 32'd3, 32'd0);
  endtask

  // One full fetch/decode transaction; entered and left in FETCH at #1 after an edge.
  task automatic fetch_cycle(input int unsigned ack_dly, input logic [31:0] word,
                             input int unsigned rdy_dly, input bit spurious,
                             input bit j, input bit b, input bit z);
    chk_fetching("fetch");
    for (int unsigned i = 0; i < ack_dly; i++) begin
      imem_rdata = $urandom;
      step();
      chk_fetching("wait");
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("hold_valid", 32'(InstrValid), 32'd1);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_instr", Instr, word);
    chk("hold_pc", PC, exp_pc);
    chk("opcode", 32'(Opcode), word >> 26);
    chk("funct", 32'(Funct), word & 32'h3F);
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      imem_ack   = (i == 0) && spurious;
      imem_rdata = $urandom;
      step();
      imem_ack = 1'b0;
      chk("bp_instr", Instr, word);
      chk("bp_pc", PC, exp_pc);
      chk("bp_valid", 32'(InstrValid), 32'd1);
      chk("bp_req", 32'(imem_req), 32'd0);
    end
    InstrReady = 1'b1;
    Jump       = j;
    Branch     = b;
    Zero       = z;
    step();
    InstrReady = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    exp_pc  = model_next(exp_pc, word, j, b, z);
    exp_cnt = exp_cnt + 32'd1;
    chk_fetching("next");
`ifdef IFU_INSTR_COUNT_EN
    chk("count", InstrCount, exp_cnt);
`endif
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    InstrReady = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    rst = 1'b0;
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instr, 32'h0);
`ifdef IFU_INSTR_COUNT_EN
    chk("rst_count", InstrCount, 32'h0);
`endif

    // Sequential fetch, ack after 3 cycles, decode always ready.
    fetch_cycle(3, 32'h0123_4567, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_pc4", imem_addr, 32'h4);
    fetch_cycle(3, 32'h89AB_CDEF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_pc8", imem_addr, 32'h8);
    fetch_cycle(3, 32'h2222_3333, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_pcc", imem_addr, 32'hC);

    // Backpressure for 5 cycles with a spurious ack while holding.
    fetch_cycle(1, 32'hDEAD_BEEF, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_next", imem_addr, 32'h10);

    // Taken branch back to 0x0C, then not-taken at 0x10.
    fetch_cycle(0, 32'h1000_FFFE, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("br_taken", imem_addr, 32'h0C);
    fetch_cycle(0, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_cycle(0, 32'h1000_FFFE, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("br_not_taken", imem_addr, 32'h14);

    // Jump to 0, backward branch to 0xFFFF_FFFC, then wrap to 0.
    fetch_cycle(0, 32'h0800_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jmp_zero", imem_addr, 32'h0);
    fetch_cycle(0, 32'h1000_FFFE, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("br_neg", imem_addr, 32'hFFFF_FFFC);
    fetch_cycle(0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap", imem_addr, 32'h0);

    // Climb to 0x2000_0000 with maximal forward branches.
    for (int i = 0; i < 4096; i++) begin
      fetch_cycle(0, 32'h1000_7FFF, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("climb", imem_addr, 32'h2000_0000);

    // Jump with branch also asserted: jump wins.
    fetch_cycle(0, 32'h0800_0040, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("jmp_prio", imem_addr, 32'h2000_0100);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      fetch_cycle($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted together with an ack mid-fetch.
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    rst        = 1'b1;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    exp_pc   = 32'h0;
    exp_cnt  = 32'h0;
    chk("mrst_instr", Instr, 32'h0);
    chk_fetching("mrst");
`ifdef IFU_INSTR_COUNT_EN
    chk("mrst_count", InstrCount, 32'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetching("mrst_idle");
    end
    fetch_cycle(2, 32'h0000_1234, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_refetch", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
